// File: rtl/midi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : midi_pkg
// Description : Shared constants, enums and helpers for the MIDI voice writer
//               (status nibbles, parameter-RAM word layout, message kinds,
//               writer FSM states).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package midi_pkg;

  // Status-byte high nibbles and the all-notes-off controller number
  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] CTRL       = 4'hB;
  localparam logic [6:0] CC_ALL_OFF = 7'd123;

  // Parameter RAM word layout: [15] gate, [14:8] note, [7] 0, [6:0] velocity
  localparam int PRAM_GATE    = 15;
  localparam int PRAM_NOTE_HI = 14;
  localparam int PRAM_NOTE_LO = 8;
  localparam int PRAM_VEL_HI  = 6;
  localparam int PRAM_VEL_LO  = 0;

  typedef enum logic [1:0] {
    KIND_NONE    = 2'd0,
    KIND_ON      = 2'd1,
    KIND_OFF     = 2'd2,
    KIND_ALL_OFF = 2'd3
  } msg_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_PEND   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_SWEEP  = 3'd4
  } state_e;

  // Assemble one parameter RAM word; bit 7 is always zero
  function automatic logic [15:0] pram_word(input logic       gate,
                                            input logic [6:0] note,
                                            input logic [6:0] vel);
    logic [15:0] w;
    w = '0;
    w[PRAM_GATE]                 = gate;
    w[PRAM_NOTE_HI:PRAM_NOTE_LO] = note;
    w[PRAM_VEL_HI:PRAM_VEL_LO]   = vel;
    return w;
  endfunction

  // Classify a channel message; anything off-channel or unrecognised is NONE
  function automatic msg_kind_e decode_msg(input logic [3:0] ch,
                                           input logic [7:0] status,
                                           input logic [6:0] d1,
                                           input logic [6:0] d2);
    msg_kind_e k;
    k = KIND_NONE;
    if (status[3:0] == ch) begin
      if (status[7:4] == NOTE_ON && d2 != 7'd0) begin
        k = KIND_ON;
      end else if (status[7:4] == NOTE_OFF || status[7:4] == NOTE_ON) begin
        // Note-on with zero velocity is a note-off by MIDI running convention
        k = KIND_OFF;
      end else if (status[7:4] == CTRL && d1 == CC_ALL_OFF) begin
        k = KIND_ALL_OFF;
      end
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/voice_alloc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : voice_alloc
// Description : Combinational voice search. Finds the lowest-index free voice
//               and the lowest-index active voice holding a given note.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module voice_alloc #(
  parameter int VOICE_W = 4
) (
  input  logic [(2**VOICE_W)-1:0]     active_i,
  input  logic [7*(2**VOICE_W)-1:0]   notes_i,
  input  logic [6:0]                  note_i,
  output logic                        free_found_o,
  output logic [VOICE_W-1:0]          free_idx_o,
  output logic                        match_found_o,
  output logic [VOICE_W-1:0]          match_idx_o
);

  localparam int NUM_VOICES = 2**VOICE_W;

  // Priority encoders: scan from the top so the lowest index wins
  always_comb begin
    free_found_o  = 1'b0;
    free_idx_o    = '0;
    match_found_o = 1'b0;
    match_idx_o   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_i[i]) begin
        free_found_o = 1'b1;
        free_idx_o   = VOICE_W'(i);
      end
      if (active_i[i] && notes_i[7*i +: 7] == note_i) begin
        match_found_o = 1'b1;
        match_idx_o   = VOICE_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_voice_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : midi_voice_writer
// Description : Accepts parsed MIDI channel messages, allocates/releases
//               voices and writes gate/note/velocity words into the voice
//               parameter RAM, only while the scanner's update window is open.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module midi_voice_writer
  import midi_pkg::*;
#(
  parameter int VOICE_W = 4,
  parameter int CHANNEL = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      msg_valid_i,
  output logic                      msg_ready_o,
  input  logic [7:0]                msg_status_i,
  input  logic [6:0]                msg_data1_i,
  input  logic [6:0]                msg_data2_i,
  input  logic                      upd_window_i,
  output logic                      upd_done_o,
  output logic                      pram_we_o,
  output logic [VOICE_W-1:0]        pram_addr_o,
  output logic [15:0]               pram_data_o,
  output logic [(2**VOICE_W)-1:0]   voices_busy_o
);

  localparam int         NUM_VOICES  = 2**VOICE_W;
  localparam logic [3:0] CHANNEL_NIB = 4'(CHANNEL);

  state_e                    state_q;
  msg_kind_e                 kind_q;
  logic [6:0]                note_in_q;
  logic [6:0]                vel_in_q;
  logic [VOICE_W-1:0]        voice_q;
  logic [VOICE_W-1:0]        steal_ptr_q;
  logic [VOICE_W-1:0]        sweep_idx_q;
  logic [NUM_VOICES-1:0]     active_q;
  logic [7*NUM_VOICES-1:0]   notes_q;

  logic                      msg_ready_q;
  logic                      upd_done_q;
  logic                      pram_we_q;
  logic [VOICE_W-1:0]        pram_addr_q;
  logic [15:0]               pram_data_q;

  logic                      free_found;
  logic [VOICE_W-1:0]        free_idx;
  logic                      match_found;
  logic [VOICE_W-1:0]        match_idx;

  voice_alloc #(
    .VOICE_W (VOICE_W)
  ) u_alloc (
    .active_i      (active_q),
    .notes_i       (notes_q),
    .note_i        (note_in_q),
    .free_found_o  (free_found),
    .free_idx_o    (free_idx),
    .match_found_o (match_found),
    .match_idx_o   (match_idx)
  );

  // Writer FSM with registered RAM-port and handshake outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_NONE;
      note_in_q   <= '0;
      vel_in_q    <= '0;
      voice_q     <= '0;
      steal_ptr_q <= '0;
      sweep_idx_q <= '0;
      active_q    <= '0;
      notes_q     <= '0;
      msg_ready_q <= 1'b0;
      upd_done_q  <= 1'b0;
      pram_we_q   <= 1'b0;
      pram_addr_q <= '0;
      pram_data_q <= '0;
    end else begin
      pram_we_q  <= 1'b0;
      upd_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Nothing is pending here, so an open window is released at once
          upd_done_q <= upd_window_i;
          if (msg_valid_i && msg_ready_q) begin
            kind_q      <= decode_msg(CHANNEL_NIB, msg_status_i, msg_data1_i, msg_data2_i);
            note_in_q   <= msg_data1_i;
            vel_in_q    <= msg_data2_i;
            msg_ready_q <= 1'b0;
            state_q     <= ST_DECODE;
          end else begin
            msg_ready_q <= 1'b1;
          end
        end

        ST_DECODE: begin
          case (kind_q)
            KIND_ON: begin
              if (free_found) begin
                voice_q <= free_idx;
              end else begin
                // All voices busy: steal round-robin
                voice_q     <= steal_ptr_q;
                steal_ptr_q <= steal_ptr_q + 1'b1;
              end
              state_q <= ST_PEND;
            end
            KIND_OFF: begin
              if (match_found) begin
                voice_q <= match_idx;
                state_q <= ST_PEND;
              end else begin
                msg_ready_q <= 1'b1;
                state_q     <= ST_IDLE;
              end
            end
            KIND_ALL_OFF: begin
              sweep_idx_q <= '0;
              state_q     <= ST_SWEEP;
            end
            default: begin
              msg_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          endcase
        end

        ST_PEND: begin
          if (upd_window_i) begin
            pram_we_q   <= 1'b1;
            pram_addr_q <= voice_q;
            upd_done_q  <= 1'b1;
            if (kind_q == KIND_ON) begin
              pram_data_q                  <= pram_word(1'b1, note_in_q, vel_in_q);
              active_q[voice_q]            <= 1'b1;
              notes_q[7*int'(voice_q) +: 7] <= note_in_q;
            end else begin
              pram_data_q       <= pram_word(1'b0, notes_q[7*int'(voice_q) +: 7], 7'd0);
              active_q[voice_q] <= 1'b0;
            end
            state_q <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          msg_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        ST_SWEEP: begin
          // One release per open-window cycle; a closed window simply holds
          if (upd_window_i) begin
            pram_we_q             <= 1'b1;
            pram_addr_q           <= sweep_idx_q;
            pram_data_q           <= pram_word(1'b0, notes_q[7*int'(sweep_idx_q) +: 7], 7'd0);
            active_q[sweep_idx_q] <= 1'b0;
            sweep_idx_q           <= sweep_idx_q + 1'b1;
            if (&sweep_idx_q) begin
              upd_done_q  <= 1'b1;
              msg_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end

        default: begin
          msg_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign msg_ready_o   = msg_ready_q;
  assign upd_done_o    = upd_done_q;
  assign pram_we_o     = pram_we_q;
  assign pram_addr_o   = pram_addr_q;
  assign pram_data_o   = pram_data_q;
  assign voices_busy_o = active_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module      : tb_midi_voice_writer
// Description : Directed + randomized bench for midi_voice_writer with a
//               voice-table reference model.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_midi_voice_writer;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  msg_status;
  logic [6:0]  msg_data1;
  logic [6:0]  msg_data2;
  logic        upd_window;
  logic        upd_done;
  logic        pram_we;
  logic [3:0]  pram_addr;
  logic [15:0] pram_data;
  logic [15:0] voices_busy;

  always #5 clk = ~clk;

  midi_voice_writer #(
    .VOICE_W (4),
    .CHANNEL (0)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .msg_valid_i   (msg_valid),
    .msg_ready_o   (msg_ready),
    .msg_status_i  (msg_status),
    .msg_data1_i   (msg_data1),
    .msg_data2_i   (msg_data2),
    .upd_window_i  (upd_window),
    .upd_done_o    (upd_done),
    .pram_we_o     (pram_we),
    .pram_addr_o   (pram_addr),
    .pram_data_o   (pram_data),
    .voices_busy_o (voices_busy)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned c;
    logic [3:0]  a;
    logic [15:0] d;
    logic        done;
  } wr_t;
  wr_t wq[$];

  // Capture every RAM write with its cycle number
  always @(negedge clk) begin
    if (pram_we === 1'b1) wq.push_back('{cyc, pram_addr, pram_data, upd_done});
  end

  // Reference voice table
  bit          m_active[NV];
  logic [6:0]  m_note[NV];
  bit          m_known[NV];
  int          m_steal;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] busy_vec();
    logic [15:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_active[i];
    return r;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NV; i++) if (!m_active[i]) return i;
    return -1;
  endfunction

  function automatic int match_note(input logic [6:0] n);
    for (int i = 0; i < NV; i++) if (m_active[i] && m_note[i] == n) return i;
    return -1;
  endfunction

  function automatic bit sounding(input logic [6:0] n);
    return match_note(n) >= 0;
  endfunction

  // Predict the single-voice write a message causes (steal pointer advances here)
  task automatic predict(input logic [7:0] st, input logic [6:0] a, input logic [6:0] b,
                         output bit we, output bit on, output int v, output logic [15:0] d);
    we = 0; on = 0; v = 0; d = '0;
    if (st[3:0] == 4'd0) begin
      if (st[7:4] == 4'h9 && b != 7'd0) begin
        v = lowest_free();
        if (v < 0) begin
          v = m_steal;
          m_steal = (m_steal + 1) % NV;
        end
        we = 1; on = 1;
        d = {1'b1, a, 1'b0, b};
      end else if (st[7:4] == 4'h8 || st[7:4] == 4'h9) begin
        v = match_note(a);
        if (v >= 0) begin
          we = 1;
          d = {1'b0, m_note[v], 8'h00};
        end else begin
          v = 0;
        end
      end
    end
  endtask

  task automatic commit(input bit on, input int v, input logic [6:0] a);
    if (on) begin
      m_active[v] = 1; m_note[v] = a; m_known[v] = 1;
    end else begin
      m_active[v] = 0;
    end
  endtask

  task automatic send(input logic [7:0] st, input logic [6:0] a, input logic [6:0] b,
                      output int unsigned t);
    int k;
    k = 0;
    while (msg_ready !== 1'b1 && k < 100) begin tick(); k++; end
    if (k >= 100) check("ready_wait", {31'd0, msg_ready}, 32'd1);
    msg_valid = 1; msg_status = st; msg_data1 = a; msg_data2 = b;
    t = cyc;
    tick();
    msg_valid = 0;
  endtask

  task automatic wait_write(input string tag, output bit got, output wr_t w);
    int k;
    k = 0;
    got = 0;
    w = '{0, 4'd0, 16'd0, 1'b0};
    while (wq.size() == 0 && k < 200) begin tick(); k++; end
    if (wq.size() == 0) check({tag, "_write_seen"}, 32'(wq.size()), 32'd1);
    else begin got = 1; w = wq.pop_front(); end
  endtask

  // Send one message with the window as currently set and check its effect
  task automatic run_msg(input string tag, input logic [7:0] st, input logic [6:0] a,
                         input logic [6:0] b, input bit chk_lat);
    bit we, on, got; int v; logic [15:0] d; int unsigned t; wr_t w;
    predict(st, a, b, we, on, v, d);
    send(st, a, b, t);
    if (we) begin
      wait_write(tag, got, w);
      if (got) begin
        check({tag, "_addr"}, 32'(w.a), 32'(v));
        check({tag, "_data"}, 32'(w.d), 32'(d));
        check({tag, "_done"}, 32'(w.done), 32'd1);
        if (chk_lat) check({tag, "_latency"}, w.c - t, 32'd3);
      end
      commit(on, v, a);
      tick();
    end else begin
      repeat (8) tick();
      check({tag, "_nowrite"}, 32'(wq.size()), 32'd0);
    end
    check({tag, "_busy"}, 32'(voices_busy), 32'(busy_vec()));
  endtask

  task automatic do_reset(input string tag);
    msg_valid = 0;
    reset = 1;
    repeat (3) tick();
    check({tag, "_rst_ready"}, 32'(msg_ready), 32'd0);
    check({tag, "_rst_we"},    32'(pram_we),   32'd0);
    check({tag, "_rst_done"},  32'(upd_done),  32'd0);
    check({tag, "_rst_addr"},  32'(pram_addr), 32'd0);
    check({tag, "_rst_data"},  32'(pram_data), 32'd0);
    check({tag, "_rst_busy"},  32'(voices_busy), 32'd0);
    reset = 0;
    for (int i = 0; i < NV; i++) m_active[i] = 0;
    m_steal = 0;
    tick();
    check({tag, "_ready_after"}, 32'(msg_ready), 32'd1);
    wq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit we, on, got; int v; logic [15:0] d; int unsigned t, wcyc; wr_t w;
    int bad_ready, bad_we, extra_done;
    logic [6:0] n;

    msg_valid = 0; msg_status = '0; msg_data1 = '0; msg_data2 = '0;
    upd_window = 1; reset = 1;
    for (int i = 0; i < NV; i++) begin m_active[i] = 0; m_note[i] = '0; m_known[i] = 0; end
    m_steal = 0;
    do_reset("init");

    // Basic note-on with the window held open
    run_msg("on60", 8'h90, 7'd60, 7'd100, 1);
    check("on60_busy_exact", 32'(voices_busy), 32'h0001);

    // Release of a middle voice and reuse of it
    run_msg("on62", 8'h90, 7'd62, 7'd80, 1);
    run_msg("on64", 8'h90, 7'd64, 7'd70, 1);
    check("three_busy", 32'(voices_busy), 32'h0007);
    run_msg("off62", 8'h80, 7'd62, 7'd0, 1);
    check("off62_busy", 32'(voices_busy), 32'h0005);
    run_msg("reuse", 8'h90, 7'($urandom_range(0, 127)), 7'($urandom_range(1, 127)), 1);

    // Fill all voices, then steal
    do_reset("fill");
    for (int i = 0; i < 17; i++)
      run_msg("fill_on", 8'h90, 7'($urandom_range(0, 127)), 7'($urandom_range(1, 127)), 1);
    check("steal_ptr_next", 32'(m_steal), 32'd1);
    run_msg("steal1", 8'h90, 7'($urandom_range(0, 127)), 7'($urandom_range(1, 127)), 1);

    // Note-off for a note that is not sounding
    n = 7'd0;
    for (int i = 0; i < 128; i++) if (!sounding(7'(i))) begin n = 7'(i); break; end
    run_msg("off_silent", 8'h80, n, 7'd64, 0);

    // Random mix of messages
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 4))
        0: run_msg("rnd_on", 8'h90, 7'($urandom_range(0, 127)), 7'($urandom_range(1, 127)), 1);
        1: begin
          v = int'($urandom_range(0, NV - 1));
          run_msg("rnd_off", 8'h80, m_note[v], 7'($urandom_range(0, 127)), 0);
        end
        2: run_msg("rnd_on0", 8'h90, 7'($urandom_range(0, 127)), 7'd0, 0);
        3: run_msg("rnd_pc", 8'hC0, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 0);
        default: run_msg("rnd_cc", 8'hB0, 7'($urandom_range(0, 122)), 7'($urandom_range(0, 127)), 0);
      endcase
    end

    // Window closed for 20 cycles: message waits, nothing written
    upd_window = 0;
    n = 7'($urandom_range(0, 127));
    predict(8'h90, n, 7'd33, we, on, v, d);
    send(8'h90, n, 7'd33, t);
    bad_ready = 0; bad_we = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (msg_ready !== 1'b0) bad_ready++;
      if (pram_we !== 1'b0) bad_we++;
    end
    check("winlow_ready", 32'(bad_ready), 32'd0);
    check("winlow_we", 32'(bad_we), 32'd0);
    upd_window = 1;
    wcyc = cyc;
    wait_write("winlow", got, w);
    if (got) begin
      // PEND samples the open window; the registered write follows next cycle
      check("winlow_wcycle", w.c - wcyc, 32'd1);
      check("winlow_addr", 32'(w.a), 32'(v));
      check("winlow_data", 32'(w.d), 32'(d));
    end
    commit(on, v, n);
    tick();

    // All-notes-off with a 4-open / 4-closed window pattern
    send(8'hB0, 7'd123, 7'd0, t);
    extra_done = 0;
    for (int k = 0; k < 400 && wq.size() < NV; k++) begin
      upd_window = ((k / 4) % 2) == 0;
      tick();
      if (upd_done === 1'b1 && pram_we !== 1'b1) extra_done++;
    end
    upd_window = 1;
    check("sweep_count", 32'(wq.size()), 32'd16);
    check("sweep_extra_done", 32'(extra_done), 32'd0);
    for (int i = 0; i < NV && wq.size() > 0; i++) begin
      w = wq.pop_front();
      check("sweep_addr", 32'(w.a), 32'(i));
      check("sweep_gate", 32'(w.d[15]), 32'd0);
      check("sweep_vel", 32'(w.d[7:0]), 32'd0);
      if (m_known[i]) check("sweep_note", 32'(w.d[14:8]), 32'(m_note[i]));
      check("sweep_done", 32'(w.done), (i == NV - 1) ? 32'd1 : 32'd0);
      m_active[i] = 0;
    end
    tick();
    check("sweep_busy", 32'(voices_busy), 32'd0);

    // Reset while a write is pending
    run_msg("pre_rst_on", 8'h90, 7'd50, 7'd50, 1);
    upd_window = 0;
    send(8'h90, 7'd51, 7'd51, t);
    tick(); tick();
    do_reset("pend");
    upd_window = 1;
    repeat (10) tick();
    check("pend_rst_nowrite", 32'(wq.size()), 32'd0);
    check("pend_rst_busy", 32'(voices_busy), 32'd0);

    // Other channel is ignored
    run_msg("chan1", 8'h91, 7'd60, 7'd100, 0);
    // Same channel still works afterwards and starts from voice 0
    run_msg("post_on", 8'h90, 7'd72, 7'd90, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
